shift_sub_divider: RTL and testbench

//  Sequential restoring (shift-subtract) unsigned divider; inverse operation of the shift-add multiplier.

---
 rtl/shift_sub_divider.sv | 132 +++++++++++++
 tb/tb_shift_sub_divider.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/shift_sub_divider.sv
// Sequential restoring (shift-subtract) unsigned divider: one quotient bit per
// SHIFT/SUB(/RESTORE) pass, started by a start pulse, finished with a one-cycle done.
module shift_sub_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_SUB,
        S_RESTORE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH:0]   r_a;
    logic [WIDTH:0]   w_a_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] w_m_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic             r_dbz;
    logic             w_dbz_next;

    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_sum;

    // The extra MSB of the partial remainder acts as the sign of the trial subtraction.
    assign w_diff = r_a - {1'b0, r_m};
    assign w_sum  = r_a + {1'b0, r_m};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_q     <= w_q_next;
            r_m     <= w_m_next;
            r_cnt   <= w_cnt_next;
            r_dbz   <= w_dbz_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_q_next     = r_q;
        w_m_next     = r_m;
        w_cnt_next   = r_cnt;
        w_dbz_next   = r_dbz;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a_next   = '0;
                    w_q_next   = dividend;
                    w_m_next   = divisor;
                    w_cnt_next = CW'(WIDTH);
                    w_dbz_next = 1'b0;
                    if (divisor == '0) begin
                        // Divide-by-zero short-circuits straight to DONE with saturated quotient.
                        w_q_next     = '1;
                        w_a_next     = {1'b0, dividend};
                        w_dbz_next   = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_SHIFT;
                    end
                end
            end

            S_SHIFT: begin
                {w_a_next, w_q_next} = {r_a[WIDTH-1:0], r_q, 1'b0};
                w_state_next         = S_SUB;
            end

            S_SUB: begin
                w_a_next   = w_diff;
                w_cnt_next = r_cnt - CW'(1);
                if (!w_diff[WIDTH]) begin
                    w_q_next     = {r_q[WIDTH-1:1], 1'b1};
                    w_state_next = (r_cnt == CW'(1)) ? S_DONE : S_SHIFT;
                end else begin
                    w_q_next     = {r_q[WIDTH-1:1], 1'b0};
                    w_state_next = S_RESTORE;
                end
            end

            S_RESTORE: begin
                w_a_next     = w_sum;
                w_state_next = (r_cnt == '0) ? S_DONE : S_SHIFT;
            end

            S_DONE: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign quotient    = r_q;
    assign remainder   = r_a[WIDTH-1:0];
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed and swept checks of shift_sub_divider (WIDTH=8): results, latency,
// busy/done framing, divide-by-zero, ignored starts and mid-operation reset.
module tb_shift_sub_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    shift_sub_divider #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int zeros8(input logic [7:0] q);
        int n = 0;
        for (int i = 0; i < 8; i++) if (!q[i]) n++;
        return n;
    endfunction

    // Issue one request from IDLE and check its results, latency and framing.
    // With noise=1, start is held high with other operands while busy.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_q, input logic [7:0] exp_r,
                          input logic exp_dbz, input int exp_cyc, input bit noise);
        int cycles;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = noise;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        cycles   = 1;
        while (done !== 1'b1 && cycles < 60) begin
            chk("busy_during_op", busy, 1);
            @(posedge clk); #1;
            cycles++;
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("latency", cycles, exp_cyc);
        chk("busy_in_done", busy, 1);
        chk("quotient", quotient, exp_q);
        chk("remainder", remainder, exp_r);
        chk("div_by_zero", div_by_zero, exp_dbz);
        if (b != 0) chk("rem_lt_divisor", (remainder < b), 1);
        $display("op %0d/%0d -> q=%0d r=%0d dbz=%0d cycles=%0d", a, b, quotient, remainder,
                 div_by_zero, cycles);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
        chk("quotient_held", quotient, exp_q);
        chk("remainder_held", remainder, exp_r);
    endtask

    task automatic model_op(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] q;
        logic [7:0] r;
        if (b == 0) begin
            run_op(a, b, 8'hFF, a, 1'b1, 1, 1'b0);
        end else begin
            q = a / b;
            r = a % b;
            chk("identity", 32'(q) * 32'(b) + 32'(r), 32'(a));
            run_op(a, b, q, r, 1'b0, 17 + zeros8(q), 1'b0);
        end
    endtask

    initial begin
        logic [7:0] edge_vals [3];
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dbz", div_by_zero, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors with hand-derived results and latencies.
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 22, 1'b0);
        run_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 17, 1'b0);
        run_op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 25, 1'b0);
        run_op(8'd37, 8'd0, 8'hFF, 8'd37, 1'b1, 1, 1'b0);
        run_op(8'd200, 8'd10, 8'd20, 8'd0, 1'b0, 23, 1'b0);
        run_op(8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 25, 1'b0);

        // start held through busy and DONE with changing operands is ignored.
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 22, 1'b1);
        run_op(8'd200, 8'd10, 8'd20, 8'd0, 1'b0, 23, 1'b0);

        // Asynchronous reset in cycle 9 of 100/7.
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("midop_busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        $display("reset asserted mid-operation");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_rst", busy, 0);
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 22, 1'b0);

        // Sweep: all boundary pairs over {0,1,255}, then random pairs.
        edge_vals[0] = 8'd0;
        edge_vals[1] = 8'd1;
        edge_vals[2] = 8'd255;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                model_op(edge_vals[i], edge_vals[j]);
        for (int k = 0; k < 2000; k++)
            model_op(8'($urandom), 8'($urandom_range(0, 255)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
